// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Each CONV cycle does one right shift of {bcd, bin}. It then applies the
// per-nibble "subtract 3 if >= 8" correction. After BIN_W shifts, bin holds the result.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   bcd_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [BIN_W-1:0]      binary_o,
    output logic                  err_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   binary_q, binary_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_fix;
    logic [BIN_W-1:0]   bin_shift;
    logic               bcd_bad;

    // A nibble that is >= 8 after the shift held a "half ten". Subtracting 3
    // restores a valid BCD digit. Valid input never exceeds 12, so no underflow occurs.
    function automatic logic [3:0] fix_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    // Any digit above 9 makes the whole input invalid.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One shift step: the LSB of the BCD register enters the binary MSB,
    // then each BCD nibble is corrected independently (no cross-nibble carry).
    always_comb begin
        bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
        bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_fix   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            bcd_fix[4*d +: 4] = fix_nibble(bcd_shift[4*d +: 4]);
        end
        bcd_bad = has_bad_digit(bcd_i);
    end

    // Next-state and datapath control. Results are latched on the edge that
    // enters DONE, so binary_o/err_o are already valid while done_o is high.
    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (bcd_bad) begin
                        state_d  = DONE;
                        binary_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        bcd_d   = bcd_i;
                        bin_d   = '0;
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                bcd_d = bcd_fix;
                bin_d = bin_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d  = DONE;
                    binary_d = bin_shift;
                    err_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            err_q    <= err_d;
        end
    end

    assign busy_o   = (state_q == CONV);
    assign done_o   = (state_q == DONE);
    assign binary_o = binary_q;
    assign err_o    = err_q;

endmodule
